// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, NOP encoding,
// and instruction field positions shared by fetch, hazard and decode.
package mips_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;

  function automatic logic [5:0] f_opcode(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/mips_fetch_stage_ifid_reg.sv
// IF/ID pipeline register with load, hold and flush (flush wins).
// Ports: clk, rst_n, i_load, i_flush, i_instr, i_pc4 -> o_valid, o_instr, o_pc4.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc4,
  output logic              o_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_instr <= NOP_INSTR;
      o_pc4   <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_instr <= NOP_INSTR;
      o_pc4   <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_instr <= i_instr;
      o_pc4   <= i_pc4;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, synchronous imem driver, skid buffer, IF/ID.
// Ports: clk, rst_n, pc_en, if_en, redirect_valid/pc, imem_addr/rdata, ifid_*;
// optional stall_cnt/flush_cnt counters when IF_PERF_CNT_EN is defined.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_en,
  input  logic              if_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [5:0]        ifid_opcode,
  output logic [4:0]        ifid_rs,
  output logic [4:0]        ifid_rt
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(3);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc_q;
  logic [ADDR_W-1:0] r_f_pc;
  logic              r_f_valid;
  logic [31:0]       r_hold_instr;

  logic              w_stall;
  logic              w_issue;
  logic              w_park;
  logic              w_flush;
  logic              w_ifid_load;
  logic [31:0]       w_ifid_src;

  // A mismatch between the two enables is treated as a stall.
  assign w_stall   = ~(pc_en & if_en);
  assign imem_addr = r_pc_q;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_park      = 1'b0;
    w_flush     = 1'b0;
    w_ifid_load = 1'b0;
    w_ifid_src  = imem_rdata;
    if (redirect_valid) begin
      w_flush     = 1'b1;
      w_state_nxt = FILL;
    end else begin
      unique case (r_state)
        FILL: begin
          if (!w_stall) begin
            w_issue     = 1'b1;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (!w_stall) begin
            w_ifid_load = r_f_valid;
            w_issue     = 1'b1;
          end else begin
            // Memory moves on next cycle; park this response.
            w_park      = 1'b1;
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          // While stalled, imem_rdata reflects pc_q, not f_pc: ignore it.
          if (!w_stall) begin
            w_ifid_load = r_f_valid;
            w_ifid_src  = r_hold_instr;
            w_issue     = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_pc_q       <= RESET_PC;
      r_f_pc       <= '0;
      r_f_valid    <= 1'b0;
      r_hold_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      if (w_flush) begin
        r_pc_q    <= redirect_pc & ALIGN_M;
        r_f_valid <= 1'b0;
      end else if (w_issue) begin
        r_pc_q    <= r_pc_q + PC_STEP;
        r_f_pc    <= r_pc_q;
        r_f_valid <= 1'b1;
      end
      if (w_park) begin
        r_hold_instr <= imem_rdata;
      end
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W)
  ) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ifid_load),
    .i_flush (w_flush),
    .i_instr (w_ifid_src),
    .i_pc4   (r_f_pc + PC_STEP),
    .o_valid (ifid_valid),
    .o_instr (ifid_instr),
    .o_pc4   (ifid_pc4)
  );

  assign ifid_opcode = f_opcode(ifid_instr);
  assign ifid_rs     = f_rs(ifid_instr);
  assign ifid_rt     = f_rt(ifid_instr);

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (!redirect_valid && w_stall && r_state != FILL
          && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (redirect_valid && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed table, corner
// sequences and randomized stall/redirect traffic vs a queue model.
module tb_mips_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic        if_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_opcode;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  mips_fetch_stage #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_en          (pc_en),
    .if_en          (if_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .ifid_opcode    (ifid_opcode),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct word for every aligned address (odd multiplier is a bijection).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1;
  endfunction

  // Synchronous instruction memory: data one cycle after the address.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: next fetch address, queue of fetched-not-delivered
  // addresses, and the IF/ID contents. Stalled cycles freeze everything.
  logic [31:0] m_next;
  logic [31:0] m_q[$];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  int          m_stalls;
  int          m_flushes;

  task automatic model_reset();
    m_next    = 32'h0;
    m_q.delete();
    m_valid   = 1'b0;
    m_instr   = 32'h0;
    m_pc4     = 32'h0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic model_edge(input bit pe, input bit ie, input bit rv,
                            input logic [31:0] rpc);
    logic [31:0] a;
    if (rv) begin
      if (m_flushes < 65535) m_flushes++;
      m_next  = {rpc[31:2], 2'b00};
      m_q.delete();
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
    end else if (pe && ie) begin
      if (m_q.size() > 0) begin
        a       = m_q.pop_front();
        m_valid = 1'b1;
        m_instr = mem_word(a);
        m_pc4   = a + 32'd4;
      end
      m_q.push_back(m_next);
      m_next = m_next + 32'd4;
    end else if (m_q.size() > 0) begin
      if (m_stalls < 65535) m_stalls++;
    end
  endtask

  task automatic cmp_model();
    chk("imem_addr", imem_addr, m_next);
    chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_opcode", {26'h0, ifid_opcode}, m_instr >> 26);
    chk("ifid_rs", {27'h0, ifid_rs}, (m_instr >> 21) % 32);
    chk("ifid_rt", {27'h0, ifid_rt}, (m_instr >> 16) % 32);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", {16'h0, stall_cnt}, m_stalls);
    chk("flush_cnt", {16'h0, flush_cnt}, m_flushes);
`endif
  endtask

  // Called at a negedge: drive, clock, update model, compare at negedge.
  task automatic step(input bit pe, input bit ie, input bit rv,
                      input logic [31:0] rpc);
    pc_en          = pe;
    if_en          = ie;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_edge(pe, ie, rv, rpc);
    @(negedge clk);
    cmp_model();
  endtask

  typedef struct {
    bit          pe;
    bit          ie;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc4;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit pe, input bit ie, input bit rv,
                     input logic [31:0] rpc, input bit ev,
                     input logic [31:0] epc4, input logic [31:0] eaddr);
    vec_t v;
    v = '{pe, ie, rv, rpc, ev, epc4, eaddr};
    tbl.push_back(v);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_ifid_instr", ifid_instr, 32'h0);
    chk("rst_ifid_pc4", ifid_pc4, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    pc_en          = 1'b1;
    if_en          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    #2;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_ifid_pc4", ifid_pc4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // pe ie rv rpc | valid pc4 addr (after the edge)
    add(1, 1, 0, 32'h0,         0, 32'h0,   32'h4);
    add(1, 1, 0, 32'h0,         1, 32'h4,   32'h8);
    add(1, 1, 0, 32'h0,         1, 32'h8,   32'hC);
    add(1, 1, 0, 32'h0,         1, 32'hC,   32'h10);
    add(0, 0, 0, 32'h0,         1, 32'hC,   32'h10);
    add(1, 1, 0, 32'h0,         1, 32'h10,  32'h14);
    add(1, 1, 0, 32'h0,         1, 32'h14,  32'h18);
    add(0, 0, 0, 32'h0,         1, 32'h14,  32'h18);
    add(0, 0, 0, 32'h0,         1, 32'h14,  32'h18);
    add(0, 0, 0, 32'h0,         1, 32'h14,  32'h18);
    add(1, 1, 0, 32'h0,         1, 32'h18,  32'h1C);
    add(1, 1, 0, 32'h0,         1, 32'h1C,  32'h20);
    add(1, 1, 1, 32'h103,       0, 32'h0,   32'h100);
    add(1, 1, 0, 32'h0,         0, 32'h0,   32'h104);
    add(1, 1, 0, 32'h0,         1, 32'h104, 32'h108);
    add(0, 0, 0, 32'h0,         1, 32'h104, 32'h108);
    add(0, 0, 1, 32'h200,       0, 32'h0,   32'h200);
    add(1, 1, 0, 32'h0,         0, 32'h0,   32'h204);
    add(1, 1, 0, 32'h0,         1, 32'h204, 32'h208);
    add(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,   32'hFFFF_FFFC);
    add(1, 1, 0, 32'h0,         0, 32'h0,   32'h0);
    add(1, 1, 0, 32'h0,         1, 32'h0,   32'h4);
    add(1, 0, 0, 32'h0,         1, 32'h0,   32'h4);
    add(1, 1, 0, 32'h0,         1, 32'h4,   32'h8);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].pe, tbl[i].ie, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_valid", i), {31'h0, ifid_valid},
          {31'h0, tbl[i].ev});
      chk($sformatf("tbl%0d_pc4", i), ifid_pc4, tbl[i].epc4);
      chk($sformatf("tbl%0d_instr", i), ifid_instr,
          tbl[i].ev ? mem_word(tbl[i].epc4 - 32'd4) : 32'h0);
    end

`ifdef IF_PERF_CNT_EN
    chk("tbl_flush_cnt", {16'h0, flush_cnt}, 32'd3);
    chk("tbl_stall_cnt", {16'h0, stall_cnt}, 32'd6);
`endif

    // Reset asserted mid-stall, then mid-redirect.
    step(1, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    async_reset();
    step(1, 1, 0, 32'h0);
    chk("post_rst_addr", imem_addr, 32'h4);
    step(1, 1, 0, 32'h0);
    pc_en          = 1'b1;
    if_en          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    async_reset();
    redirect_valid = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit          pe;
      bit          ie;
      bit          rv;
      logic [31:0] rpc;
      pe  = ($urandom_range(0, 4) != 0);
      ie  = ($urandom_range(0, 4) != 0);
      rv  = ($urandom_range(0, 12) == 0);
      rpc = ($urandom_range(0, 3) == 0)
          ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
          : $urandom;
      step(pe, ie, rv, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
